data_mem_wait: RTL and testbench



---
 rtl/mem_defs_pkg.sv | 27 ++
 rtl/data_mem_wait_counter.sv | 31 +++
 rtl/data_mem_wait.sv | 124 ++++++++++++
 tb/tb_data_mem_wait.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_defs_pkg.sv
// mem_defs: definitions shared by the data memory and the CPU top.
//   mem_state_t : request FSM state encoding (IDLE/WAIT/ACCESS/RESP)
//   clog2       : ceiling log2, usable in parameter expressions
//   DEF_DATA_W, DEF_DEPTH : default data width and word count
package mem_defs;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 128;

  typedef enum logic [1:0] {
    MEM_IDLE   = 2'd0,
    MEM_WAIT   = 2'd1,
    MEM_ACCESS = 2'd2,
    MEM_RESP   = 2'd3
  } mem_state_t;

  // Smallest r such that 2**r >= value; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/data_mem_wait_counter.sv
// wait_counter: loadable down-counter that stops at zero.
//   clock    : rising-edge clock
//   reset    : synchronous active-high, clears the count
//   load     : load load_val this edge (overrides counting)
//   load_val : value to load
//   zero     : count is currently zero
module wait_counter #(
  parameter int WIDTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/data_mem_wait.sv
// data_mem_wait: word-organised data RAM with valid/ready requests, a fixed
// number of wait states, byte-enable writes and range/alignment errors.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   req_valid/req_ready : request handshake (ready only when idle)
//   req_write, req_addr, req_wdata, req_be : request fields (byte address)
//   rsp_valid    : one-cycle response strobe
//   rsp_rdata    : read data (0 for writes and errors), held between strobes
//   rsp_error    : misaligned address or word index beyond DEPTH
//   busy         : a request is in flight
module data_mem_wait
  import mem_defs::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int ADDR_W  = 32,
  parameter int LATENCY = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_error,
  output logic                busy
);

  localparam int BE_W     = DATA_W / 8;
  localparam int OFS_W    = clog2(BE_W);
  localparam int IDX_W    = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);
  localparam int CNT_W    = (clog2(LATENCY + 1) < 1) ? 1 : clog2(LATENCY + 1);
  localparam int LOAD_VAL = (LATENCY > 0) ? LATENCY - 1 : 0;

  logic [DATA_W-1:0] mem_file [DEPTH];

  mem_state_t        state;
  logic              cap_write;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_wdata;
  logic [BE_W-1:0]   cap_be;

  logic [ADDR_W-1:0] word_idx;
  logic [IDX_W-1:0]  mem_idx;
  logic              addr_err;
  logic              accept;
  logic              cnt_zero;

  // Ready is masked by reset so a request presented together with reset
  // is never accepted.
  assign req_ready = (state == MEM_IDLE) && !reset;
  assign busy      = (state != MEM_IDLE);
  assign accept    = req_ready && req_valid;

  // Misalignment is tested with a mask so that BE_W = 1 needs no special case.
  assign word_idx = cap_addr >> OFS_W;
  assign mem_idx  = word_idx[IDX_W-1:0];
  assign addr_err = ((cap_addr & ADDR_W'(BE_W - 1)) != '0) ||
                    (word_idx >= ADDR_W'(DEPTH));

  wait_counter #(
    .WIDTH(CNT_W)
  ) u_wait_counter (
    .clock   (clock),
    .reset   (reset),
    .load    (accept),
    .load_val(CNT_W'(LOAD_VAL)),
    .zero    (cnt_zero)
  );

  // Request FSM with registered response outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= MEM_IDLE;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        MEM_IDLE: begin
          if (req_valid) begin
            cap_write <= req_write;
            cap_addr  <= req_addr;
            cap_wdata <= req_wdata;
            cap_be    <= req_be;
            if (LATENCY == 0) state <= MEM_ACCESS;
            else              state <= MEM_WAIT;
          end
        end
        MEM_WAIT: begin
          if (cnt_zero) state <= MEM_ACCESS;
        end
        MEM_ACCESS: begin
          rsp_error <= addr_err;
          if (addr_err || cap_write) rsp_rdata <= '0;
          else                       rsp_rdata <= mem_file[mem_idx];
          rsp_valid <= 1'b1;
          state     <= MEM_RESP;
        end
        MEM_RESP: begin
          state <= MEM_IDLE;
        end
        default: begin
          state <= MEM_IDLE;
        end
      endcase
    end
  end

  // Array write happens on the edge that closes ACCESS; a reset landing on
  // that edge drops the write.
  always_ff @(posedge clock) begin
    if (!reset && state == MEM_ACCESS && cap_write && !addr_err) begin
      for (int i = 0; i < BE_W; i++) begin
        if (cap_be[i]) mem_file[mem_idx][8*i +: 8] <= cap_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_wait.sv
module tb_data_mem_wait;

  localparam int LAT_A = 2;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  logic        a_req_valid, a_req_ready, a_req_write;
  logic [31:0] a_req_addr, a_req_wdata;
  logic [3:0]  a_req_be;
  logic        a_rsp_valid, a_rsp_error, a_busy;
  logic [31:0] a_rsp_rdata;

  logic        b_req_valid, b_req_ready, b_req_write;
  logic [31:0] b_req_addr;
  logic [63:0] b_req_wdata;
  logic [7:0]  b_req_be;
  logic        b_rsp_valid, b_rsp_error, b_busy;
  logic [63:0] b_rsp_rdata;

  data_mem_wait #(
    .DATA_W(32), .DEPTH(128), .ADDR_W(32), .LATENCY(LAT_A)
  ) u_dut_a (
    .clock(clock), .reset(reset),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_be(a_req_be),
    .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .rsp_error(a_rsp_error),
    .busy(a_busy)
  );

  data_mem_wait #(
    .DATA_W(64), .DEPTH(16), .ADDR_W(32), .LATENCY(0)
  ) u_dut_b (
    .clock(clock), .reset(reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_be(b_req_be),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_error(b_rsp_error),
    .busy(b_busy)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int rsp_count   = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
               name, actual, expected, cyc);
    end
  endtask

  // Reference model for instance A: one outstanding request, described by
  // its acceptance cycle; the memory operation takes effect LATENCY+1 cycles
  // later and the response is visible the cycle after that.
  logic [31:0] model_mem [128];
  bit          pend = 1'b0;
  int          acc  = 0;
  bit          m_write;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_be;
  bit          m_err;

  function automatic void model_access();
    int idx;
    m_err   = (m_addr % 4 != 0) || (m_addr / 4 >= 128);
    m_rdata = '0;
    if (!m_err) begin
      idx = int'(m_addr / 4);
      if (m_write) begin
        for (int b = 0; b < 4; b++) begin
          if (m_be[b]) model_mem[idx][8*b +: 8] = m_wdata[8*b +: 8];
        end
      end else begin
        m_rdata = model_mem[idx];
      end
    end
  endfunction

  always @(negedge clock) begin
    bit exp_busy, exp_ready, exp_valid;
    if (cyc >= 1) begin
      exp_busy  = pend && (cyc > acc);
      exp_ready = !reset && !exp_busy;
      exp_valid = pend && (cyc == acc + LAT_A + 2);
      check_output("a_req_ready", a_req_ready, exp_ready);
      check_output("a_busy", a_busy, exp_busy);
      check_output("a_rsp_valid", a_rsp_valid, exp_valid);
      if (a_rsp_valid) rsp_count++;
      if (exp_valid) begin
        check_output("a_rsp_rdata", a_rsp_rdata, m_rdata);
        check_output("a_rsp_error", a_rsp_error, m_err);
      end
      if (reset) begin
        pend = 1'b0;
      end else begin
        if (pend && cyc == acc + LAT_A + 1) model_access();
        if (exp_valid) pend = 1'b0;
        if (exp_ready && a_req_valid) begin
          pend    = 1'b1;
          acc     = cyc;
          m_write = a_req_write;
          m_addr  = a_req_addr;
          m_wdata = a_req_wdata;
          m_be    = a_req_be;
        end
      end
    end
  end

  task automatic a_issue(input bit write, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         input bit keep_valid, output int acc_cyc);
    bit done = 1'b0;
    acc_cyc     = -1;
    a_req_valid = 1'b1;
    a_req_write = write;
    a_req_addr  = addr;
    a_req_wdata = wdata;
    a_req_be    = be;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clock);
      if (a_req_ready) begin
        done    = 1'b1;
        acc_cyc = cyc;
      end
    end
    @(posedge clock);
    #1;
    if (!keep_valid) a_req_valid = 1'b0;
    check_output("a_accept_timeout", done, 1'b1);
  endtask

  task automatic a_wait_rsp(output logic [31:0] rdata, output bit err,
                            output int rsp_cyc);
    bit done = 1'b0;
    rdata   = '0;
    err     = 1'b0;
    rsp_cyc = -1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clock);
      if (a_rsp_valid) begin
        done    = 1'b1;
        rdata   = a_rsp_rdata;
        err     = a_rsp_error;
        rsp_cyc = cyc;
      end
    end
    @(posedge clock);
    #1;
    check_output("a_rsp_timeout", done, 1'b1);
  endtask

  task automatic apply_stimulus(input bit write, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] be,
                                output logic [31:0] rdata, output bit err,
                                output int lat);
    int acc_c, rsp_c;
    a_issue(write, addr, wdata, be, 1'b0, acc_c);
    a_wait_rsp(rdata, err, rsp_c);
    lat = rsp_c - acc_c;
  endtask

  task automatic b_txn(input bit write, input logic [31:0] addr,
                       input logic [63:0] wdata, output logic [63:0] rdata,
                       output bit err, output int lat);
    int acc_c = -1;
    int rsp_c = -1;
    bit acc_done = 1'b0;
    bit rsp_done = 1'b0;
    rdata       = '0;
    err         = 1'b0;
    b_req_valid = 1'b1;
    b_req_write = write;
    b_req_addr  = addr;
    b_req_wdata = wdata;
    b_req_be    = 8'hFF;
    for (int i = 0; i < 20 && !acc_done; i++) begin
      @(negedge clock);
      if (b_req_ready) begin
        acc_done = 1'b1;
        acc_c    = cyc;
      end
    end
    @(posedge clock);
    #1;
    b_req_valid = 1'b0;
    for (int i = 0; i < 20 && !rsp_done; i++) begin
      @(negedge clock);
      if (b_rsp_valid) begin
        rsp_done = 1'b1;
        rsp_c    = cyc;
        rdata    = b_rsp_rdata;
        err      = b_rsp_error;
      end
    end
    @(posedge clock);
    #1;
    check_output("b_accept_timeout", acc_done, 1'b1);
    check_output("b_rsp_timeout", rsp_done, 1'b1);
    lat = rsp_c - acc_c;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic [63:0] rd64;
    bit          er;
    int          lat, acc0, acc1, rc0;

    reset       = 1'b1;
    a_req_valid = 1'b0; a_req_write = 1'b0; a_req_addr = '0;
    a_req_wdata = '0;   a_req_be    = '0;
    b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = '0;
    b_req_wdata = '0;   b_req_be    = '0;
    for (int i = 0; i < 128; i++) begin
      model_mem[i]         = (i == 2) ? 32'hA5A5A5A5 : (32'h0BAD0000 | 32'(i));
      u_dut_a.mem_file[i]  = model_mem[i];
    end

    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;

    // Reset state
    @(negedge clock);
    check_output("reset_rsp_valid", a_rsp_valid, 1'b0);
    check_output("reset_rsp_error", a_rsp_error, 1'b0);
    check_output("reset_rsp_rdata", a_rsp_rdata, 32'h0);
    check_output("reset_busy", a_busy, 1'b0);
    check_output("reset_req_ready", a_req_ready, 1'b1);
    @(posedge clock);
    #1;

    // Full-word write and readback
    apply_stimulus(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat);
    check_output("t1_wr_latency", 64'(lat), 64'd4);
    check_output("t1_wr_error", er, 1'b0);
    check_output("t1_wr_rdata", rd, 32'h0);
    apply_stimulus(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    check_output("t1_rd_rdata", rd, 32'hDEADBEEF);

    // Byte-enable write, then an all-disabled write
    apply_stimulus(1'b1, 32'h10, 32'h000000AA, 4'b0001, rd, er, lat);
    apply_stimulus(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    check_output("t2_be_rdata", rd, 32'hDEADBEAA);
    apply_stimulus(1'b1, 32'h10, 32'h55555555, 4'h0, rd, er, lat);
    check_output("t2_be0_error", er, 1'b0);
    apply_stimulus(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    check_output("t2_be0_rdata", rd, 32'hDEADBEAA);

    // Out-of-range read, misaligned write, full readback
    apply_stimulus(1'b0, 32'h200, 32'h0, 4'hF, rd, er, lat);
    check_output("t3_range_error", er, 1'b1);
    check_output("t3_range_rdata", rd, 32'h0);
    apply_stimulus(1'b1, 32'h11, 32'hFFFFFFFF, 4'hF, rd, er, lat);
    check_output("t3_align_error", er, 1'b1);
    check_output("t3_align_rdata", rd, 32'h0);
    check_output("t3_align_latency", 64'(lat), 64'd4);
    for (int i = 0; i < 128; i++) begin
      apply_stimulus(1'b0, 32'(i * 4), 32'h0, 4'h0, rd, er, lat);
    end
    apply_stimulus(1'b0, 32'h14, 32'h0, 4'h0, rd, er, lat);
    check_output("t3_word5_rdata", rd, 32'h0BAD0005);

    // Back-to-back requests with req_valid held high
    rc0 = rsp_count;
    a_issue(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, acc0);
    a_issue(1'b0, 32'h4, 32'h0, 4'h0, 1'b0, acc1);
    a_wait_rsp(rd, er, lat);
    check_output("t4_accept_spacing", 64'(acc1 - acc0), 64'd5);
    check_output("t4_rsp_count", 64'(rsp_count - rc0), 64'd2);
    check_output("t4_rd_word1", rd, 32'h0BAD0001);

    // Reset during WAIT drops the write and its response
    rc0 = rsp_count;
    a_issue(1'b1, 32'h8, 32'h12345678, 4'hF, 1'b0, acc0);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check_output("t5_ready_after_reset", a_req_ready, 1'b1);
    repeat (6) @(posedge clock);
    #1;
    check_output("t5_no_rsp", 64'(rsp_count - rc0), 64'd0);
    apply_stimulus(1'b0, 32'h8, 32'h0, 4'h0, rd, er, lat);
    check_output("t5_word2_rdata", rd, 32'hA5A5A5A5);

    // Zero-latency 64-bit instance
    b_txn(1'b1, 32'h78, 64'h0123456789ABCDEF, rd64, er, lat);
    check_output("t6_wr_latency", 64'(lat), 64'd2);
    check_output("t6_wr_error", er, 1'b0);
    check_output("t6_wr_rdata", rd64, 64'h0);
    b_txn(1'b0, 32'h78, 64'h0, rd64, er, lat);
    check_output("t6_rd_latency", 64'(lat), 64'd2);
    check_output("t6_rd_rdata", rd64, 64'h0123456789ABCDEF);
    check_output("t6_rd_error", er, 1'b0);
    b_txn(1'b0, 32'h80, 64'h0, rd64, er, lat);
    check_output("t6_range_error", er, 1'b1);
    check_output("t6_range_rdata", rd64, 64'h0);
    check_output("t6_idle_busy", b_busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
